// File: rtl/multi_step_counter.sv
// multi_step_counter
//   Parametrised stepped counter with up/down counting, parallel load with
//   clamp, wrap or saturate at the range boundary, a combinational boundary
//   strobe and a sticky overflow flag.
//
//   The count range and both step sizes are set by the module parameters.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   en        count enable
//   x         step select (0: STEP0, 1: STEP1)
//   dir       0: count up, 1: count down
//   mode      0: wrap at the range limit, 1: saturate at the boundary
//   load      synchronous parallel load (highest priority)
//   load_val  value to load, clamped to the top of the range
//   clr_ovf   synchronous clear of ovf (loses to a simultaneous boundary event)
//   q         registered count
//   z         combinational boundary strobe, sample at the rising edge only
//   ovf       registered sticky boundary flag
module multi_step_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MOD   = 16,
  parameter int unsigned STEP0 = 2,
  parameter int unsigned STEP1 = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             x,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             z,
  output logic             ovf
);

  // Arithmetic is carried at WIDTH+1 bits so q+step never truncates.
  localparam logic [WIDTH:0]   MOD_W   = (WIDTH+1)'(MOD);
  localparam logic [WIDTH:0]   STEP0_W = (WIDTH+1)'(STEP0);
  localparam logic [WIDTH:0]   STEP1_W = (WIDTH+1)'(STEP1);
  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   step_w;
  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   ld_ext;
  logic [WIDTH:0]   sum_up;
  logic [WIDTH-1:0] nxt;
  logic             bnd;
  logic             en_g;

  always_comb begin
    step_w = x ? STEP1_W : STEP0_W;
    q_ext  = {1'b0, q_q};
    ld_ext = {1'b0, load_val};
    sum_up = q_ext + step_w;
    bnd    = 1'b0;
    nxt    = q_q;

    if (!dir) begin
      if (sum_up < MOD_W) begin
        nxt = WIDTH'(sum_up);
      end else begin
        bnd = 1'b1;
        nxt = mode ? MAX_Q : WIDTH'(sum_up - MOD_W);
      end
    end else begin
      if (q_ext >= step_w) begin
        nxt = WIDTH'(q_ext - step_w);
      end else begin
        bnd = 1'b1;
        nxt = mode ? '0 : WIDTH'(q_ext + MOD_W - step_w);
      end
    end

    // Enable is qualified by reset so the strobe stays low while held in reset.
    en_g = en & rst_n;
    z    = en_g & ~load & bnd;

    if (load) begin
      q_d = (ld_ext >= MOD_W) ? MAX_Q : load_val;
    end else if (en_g) begin
      q_d = nxt;
    end else begin
      q_d = q_q;
    end

    // Set dominates clear.
    ovf_d = z | (ovf_q & ~clr_ovf);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  assign q   = q_q;
  assign ovf = ovf_q;

endmodule
